imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Loads a program into instruction memory from a little-endian byte stream,
// holding the core in reset until every requested word has been written.
module imem_loader #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      len_words,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             we,
    output logic [31:0]      wa,
    output logic [WIDTH-1:0] wd,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      words_loaded
);

    localparam int BYTES = WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [31:0]    ENTRIES_U = 32'(ENTRIES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [15:0]      word_idx_q, word_idx_d;
    logic [15:0]      words_loaded_q, words_loaded_d;
    logic [15:0]      len_q, len_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic [WIDTH-1:0] wd_q, wd_d;
    logic [WIDTH-1:0] asm_ins;
    logic [31:0]      wa_q, wa_d;
    logic             we_q, we_d;
    logic             xfer;
    logic             last_byte;
    logic             len_ok;

    assign rx_ready     = (state_q == S_LOAD);
    assign busy         = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign done         = (state_q == S_DONE);
    assign err          = (state_q == S_ERR);
    assign cpu_hold     = (state_q != S_DONE);
    assign we           = we_q;
    assign wa           = wa_q;
    assign wd           = wd_q;
    assign words_loaded = words_loaded_q;

    assign xfer      = rx_valid && (state_q == S_LOAD);
    assign last_byte = xfer && (byte_cnt_q == LAST_BYTE);
    assign len_ok    = (len_words != 16'd0) && (32'(len_words) <= ENTRIES_U);

    always_comb begin
        asm_ins = asm_q;
        for (int i = 0; i < BYTES; i++) begin
            if (byte_cnt_q == BCW'(i)) begin
                asm_ins[i*8 +: 8] = rx_data;
            end
        end
    end

    // The completed word moves to wd_q so the next word can start assembling
    // in the same cycle the write goes out.
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        word_idx_d     = word_idx_q;
        words_loaded_d = words_loaded_q;
        len_d          = len_q;
        asm_d          = asm_q;
        wd_d           = wd_q;
        wa_d           = wa_q;
        we_d           = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    if (len_ok) begin
                        state_d        = S_LOAD;
                        byte_cnt_d     = '0;
                        word_idx_d     = '0;
                        words_loaded_d = '0;
                        len_d          = len_words;
                        asm_d          = '0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    asm_d      = asm_ins;
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    if (last_byte) begin
                        byte_cnt_d     = '0;
                        we_d           = 1'b1;
                        wa_d           = 32'(word_idx_q) << 2;
                        wd_d           = asm_ins;
                        word_idx_d     = word_idx_q + 16'd1;
                        words_loaded_d = words_loaded_q + 16'd1;
                        if (word_idx_q == len_q - 16'd1) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            byte_cnt_q     <= '0;
            word_idx_q     <= '0;
            words_loaded_q <= '0;
            len_q          <= '0;
            asm_q          <= '0;
            wd_q           <= '0;
            wa_q           <= '0;
            we_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            word_idx_q     <= word_idx_d;
            words_loaded_q <= words_loaded_d;
            len_q          <= len_d;
            asm_q          <= asm_d;
            wd_q           <= wd_d;
            wa_q           <= wa_d;
            we_q           <= we_d;
        end
    end

endmodule
